// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: the two master command/response ports and the altsyncram port A.
// The arbiter uses the slave modport; the masters and the RAM use the master modport.
interface ram_port_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 32
);
  logic            m0_req;
  logic            m0_wren;
  logic [AW-1:0]   m0_addr;
  logic [DW-1:0]   m0_wrdata;
  logic [DW/8-1:0] m0_byteena;
  logic            m0_ack;
  logic            m0_rdvalid;
  logic [DW-1:0]   m0_rddata;
  logic            m1_req;
  logic            m1_wren;
  logic [AW-1:0]   m1_addr;
  logic [DW-1:0]   m1_wrdata;
  logic [DW/8-1:0] m1_byteena;
  logic            m1_ack;
  logic            m1_rdvalid;
  logic [DW-1:0]   m1_rddata;
  logic            ram_clocken;
  logic            ram_wren;
  logic [AW-1:0]   ram_address;
  logic [DW-1:0]   ram_data;
  logic [DW/8-1:0] ram_byteena;
  logic [DW-1:0]   ram_q;
  logic            busy;
  modport slave (
    input  m0_req, m0_wren, m0_addr, m0_wrdata, m0_byteena,
    input  m1_req, m1_wren, m1_addr, m1_wrdata, m1_byteena,
    input  ram_q,
    output m0_ack, m0_rdvalid, m0_rddata, m1_ack, m1_rdvalid, m1_rddata,
    output ram_clocken, ram_wren, ram_address, ram_data, ram_byteena, busy
  );
  modport master (
    output m0_req, m0_wren, m0_addr, m0_wrdata, m0_byteena,
    output m1_req, m1_wren, m1_addr, m1_wrdata, m1_byteena,
    output ram_q,
    input  m0_ack, m0_rdvalid, m0_rddata, m1_ack, m1_rdvalid, m1_rddata,
    input  ram_clocken, ram_wren, ram_address, ram_data, ram_byteena, busy
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin sharing of altsyncram port A between two masters.
// Define RAM_ARB_INIT_EN to clear the RAM to INIT_VALUE after reset before any grant.
module ram_port_arbiter #(
  parameter int             AW         = 11,
  parameter int             DW         = 32,
  parameter int             NUMWORDS   = 2048,
  parameter logic [DW-1:0]  INIT_VALUE = '0
) (
  input logic               clock,
  input logic               rst_n,
  ram_port_arbiter_if.slave bus
);
  logic          r_last;
  logic          r_rdv0;
  logic          r_rdv1;
  logic [AW-1:0] r_addr;
  logic          w_clr;
  logic [AW-1:0] w_clr_addr;
  logic          w_run;
  logic          w_g0;
  logic          w_g1;

  if (NUMWORDS > (1 << AW)) begin : g_bad_depth
    $error("NUMWORDS exceeds 2**AW");
  end

`ifdef RAM_ARB_INIT_EN
  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_cnt;
  logic [AW-1:0] w_cnt_next;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    if (r_state == ST_CLEAR) begin
      w_cnt_next = r_cnt + 1'b1;
      w_next     = (r_cnt == AW'(NUMWORDS - 1)) ? ST_RUN : ST_CLEAR;
    end
  end

  assign w_clr      = (r_state == ST_CLEAR);
  assign w_clr_addr = r_cnt;
`else
  assign w_clr      = 1'b0;
  assign w_clr_addr = '0;
`endif

  // rst_n gates the combinational grant path so outputs sit at reset values while reset is held
  assign w_run = rst_n & ~w_clr;
  assign w_g0  = w_run & bus.m0_req & (~bus.m1_req | r_last);
  assign w_g1  = w_run & bus.m1_req & (~bus.m0_req | ~r_last);

  always_comb begin
    bus.busy        = w_clr;
    bus.m0_ack      = w_g0;
    bus.m1_ack      = w_g1;
    bus.m0_rdvalid  = r_rdv0;
    bus.m1_rdvalid  = r_rdv1;
    bus.m0_rddata   = bus.ram_q;
    bus.m1_rddata   = bus.ram_q;
    bus.ram_clocken = 1'b1;
    bus.ram_wren    = rst_n & (w_clr | (w_g0 & bus.m0_wren) | (w_g1 & bus.m1_wren));
    bus.ram_address = w_clr ? w_clr_addr : w_g1 ? bus.m1_addr : w_g0 ? bus.m0_addr : r_addr;
    bus.ram_data    = w_clr ? INIT_VALUE : w_g1 ? bus.m1_wrdata : bus.m0_wrdata;
    bus.ram_byteena = w_clr ? '1 : w_g1 ? bus.m1_byteena : bus.m0_byteena;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= 1'b1;
      r_rdv0 <= 1'b0;
      r_rdv1 <= 1'b0;
      r_addr <= '0;
    end else begin
      r_rdv0 <= w_g0 & ~bus.m0_wren;
      r_rdv1 <= w_g1 & ~bus.m1_wren;
      r_addr <= bus.ram_address;
      if (w_g0 | w_g1) r_last <= w_g1;
    end
  end
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed vectors for ram_port_arbiter against a behavioural port-A RAM.
module tb_ram_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 32;
`ifdef RAM_ARB_INIT_EN
  localparam bit            INIT_EN = 1'b1;
  localparam int            NW      = 16;
  localparam logic [31:0]   INIT_V  = 32'hA5A5_0000;
`else
  localparam bit            INIT_EN = 1'b0;
  localparam int            NW      = 2048;
  localparam logic [31:0]   INIT_V  = 32'h0;
`endif

  typedef struct packed {
    logic        r;
    logic        w;
    logic [10:0] a;
    logic [31:0] d;
    logic [3:0]  b;
  } cmd_t;

  typedef struct packed {
    cmd_t        c0;
    cmd_t        c1;
    logic        k0;
    logic        k1;
    logic        v0;
    logic        v1;
    logic        we;
    logic [10:0] ea;
    logic [31:0] ed;
  } vec_t;

  localparam cmd_t IDLE = '0;

  logic clock;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] mem [0:(1<<AW)-1];

  ram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  ram_port_arbiter #(.AW(AW), .DW(DW), .NUMWORDS(NW), .INIT_VALUE(INIT_V)) dut (
    .clock(clock),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // registered-address port A: write with byte enables, read data one cycle later
  always @(posedge clock) begin
    if (bus.ram_clocken) begin
      if (bus.ram_wren)
        for (int b = 0; b < 4; b++)
          if (bus.ram_byteena[b]) mem[bus.ram_address][8*b +: 8] <= bus.ram_data[8*b +: 8];
      bus.ram_q <= mem[bus.ram_address];
    end
  end

  function automatic cmd_t rd(input logic [10:0] a);
    rd = '{r: 1'b1, w: 1'b0, a: a, d: 32'h0, b: 4'h0};
  endfunction

  function automatic cmd_t wr(input logic [10:0] a, input logic [31:0] d, input logic [3:0] b);
    wr = '{r: 1'b1, w: 1'b1, a: a, d: d, b: b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input cmd_t c0, input cmd_t c1);
    bus.m0_req = c0.r; bus.m0_wren = c0.w; bus.m0_addr = c0.a; bus.m0_wrdata = c0.d; bus.m0_byteena = c0.b;
    bus.m1_req = c1.r; bus.m1_wren = c1.w; bus.m1_addr = c1.a; bus.m1_wrdata = c1.d; bus.m1_byteena = c1.b;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".ack0"}, 32'(bus.m0_ack), 0);
    chk({tag, ".ack1"}, 32'(bus.m1_ack), 0);
    chk({tag, ".rdv0"}, 32'(bus.m0_rdvalid), 0);
    chk({tag, ".rdv1"}, 32'(bus.m1_rdvalid), 0);
    chk({tag, ".wren"}, 32'(bus.ram_wren), 0);
    chk({tag, ".addr"}, 32'(bus.ram_address), 0);
    chk({tag, ".busy"}, 32'(bus.busy), 32'(INIT_EN));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vq[$];
    int   busy_n;
    bit   got;
    bit   ack_busy;
    bit   seen;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    bus.ram_q = '0;
    rst_n = 1'b0;
    drive(rd(11'h005), IDLE);
    tick();
    tick();
    #3;
    chk_reset("reset");
    @(posedge clock);
    #1;
    rst_n = 1'b1;

    // m0 reads address 5 from release: grant only once the clear (if any) is done
    busy_n = 0; got = 1'b0; ack_busy = 1'b0;
    for (int n = 0; n < 5000 && !got; n++) begin
      #3;
      if (bus.busy) begin
        busy_n++;
        ack_busy |= bus.m0_ack;
      end else got = bus.m0_ack;
      tick();
    end
    chk("init.busy_cycles", 32'(busy_n), 32'(INIT_EN ? NW : 0));
    chk("init.ack_while_busy", 32'(ack_busy), 0);
    chk("init.granted", 32'(got), 1);
    drive(IDLE, IDLE);
    #3;
    chk("init.rdv0", 32'(bus.m0_rdvalid), 1);
    chk("init.rddata", bus.m0_rddata, INIT_V);
    tick();

    // single-cycle vectors: {m0 cmd, m1 cmd, ack0, ack1, rdv0, rdv1, wren, address, rddata}
    vq.push_back(vec_t'{wr(11'h010, 32'hDEADBEEF, 4'hF), IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h010, 32'h0});
    vq.push_back(vec_t'{rd(11'h010), IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h010, 32'h0});
    vq.push_back(vec_t'{IDLE, IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h010, 32'hDEADBEEF});
    vq.push_back(vec_t'{IDLE, wr(11'h030, 32'h11223344, 4'hF), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h030, 32'h0});
    vq.push_back(vec_t'{IDLE, wr(11'h030, 32'h0000AB00, 4'b0010), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 11'h030, 32'h0});
    vq.push_back(vec_t'{rd(11'h030), IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 11'h030, 32'h0});
    vq.push_back(vec_t'{IDLE, IDLE, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 11'h030, 32'h1122AB44});
    vq.push_back(vec_t'{wr(11'h020, 32'hCAFEF00D, 4'hF), IDLE, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h020, 32'h0});
    vq.push_back(vec_t'{IDLE, rd(11'h020), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h020, 32'h0});
    vq.push_back(vec_t'{IDLE, IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h020, 32'hCAFEF00D});
    for (int k = 0; k < 8; k++) begin
      logic k0, v0, v1;
      k0 = (k % 2 == 0);
      v0 = (k > 0) && (k % 2 == 1);
      v1 = (k > 0) && (k % 2 == 0);
      vq.push_back(vec_t'{rd(11'h010), rd(11'h030), k0, !k0, v0, v1, 1'b0,
                          k0 ? 11'h010 : 11'h030, v0 ? 32'hDEADBEEF : v1 ? 32'h1122AB44 : 32'h0});
    end
    vq.push_back(vec_t'{IDLE, IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h030, 32'h1122AB44});
    vq.push_back(vec_t'{wr(11'h040, 32'h55667788, 4'hF), rd(11'h010), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 11'h040, 32'h0});
    vq.push_back(vec_t'{IDLE, rd(11'h010), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11'h010, 32'h0});
    vq.push_back(vec_t'{IDLE, IDLE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'h010, 32'hDEADBEEF});

    foreach (vq[i]) begin
      drive(vq[i].c0, vq[i].c1);
      #3;
      chk($sformatf("v%0d.ack0", i), 32'(bus.m0_ack), 32'(vq[i].k0));
      chk($sformatf("v%0d.ack1", i), 32'(bus.m1_ack), 32'(vq[i].k1));
      chk($sformatf("v%0d.rdv0", i), 32'(bus.m0_rdvalid), 32'(vq[i].v0));
      chk($sformatf("v%0d.rdv1", i), 32'(bus.m1_rdvalid), 32'(vq[i].v1));
      chk($sformatf("v%0d.wren", i), 32'(bus.ram_wren), 32'(vq[i].we));
      chk($sformatf("v%0d.addr", i), 32'(bus.ram_address), 32'(vq[i].ea));
      if (vq[i].v0) chk($sformatf("v%0d.rddata0", i), bus.m0_rddata, vq[i].ed);
      if (vq[i].v1) chk($sformatf("v%0d.rddata1", i), bus.m1_rddata, vq[i].ed);
      tick();
    end

    // m1 read of 0x7FF, reset pulsed in the following cycle: pending rdvalid is lost
    drive(IDLE, rd(11'h7FF));
    #3;
    chk("mid.ack1", 32'(bus.m1_ack), 1);
    tick();
    drive(IDLE, IDLE);
    rst_n = 1'b0;
    #2;
    chk_reset("mid_rst");
    tick();
    #2;
    chk_reset("mid_rst2");
    @(posedge clock);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      #3;
      seen |= bus.m1_rdvalid;
      if (!bus.busy && n >= 2) got = 1'b1;
      else tick();
    end
    chk("mid.released", 32'(got), 1);
    chk("mid.no_rdv1", 32'(seen), 0);
    drive(rd(11'h010), rd(11'h030));
    #1;
    chk("mid.last_reset_ack0", 32'(bus.m0_ack), 1);
    chk("mid.last_reset_ack1", 32'(bus.m1_ack), 0);
    tick();
    drive(IDLE, rd(11'h030));
    #3;
    chk("mid.loser_ack1", 32'(bus.m1_ack), 1);
    chk("mid.rdv0", 32'(bus.m0_rdvalid), 1);
    chk("mid.rddata0", bus.m0_rddata, 32'hDEADBEEF);
    tick();
    drive(IDLE, IDLE);
    #3;
    chk("mid.rdv1", 32'(bus.m1_rdvalid), 1);
    chk("mid.rddata1", bus.m1_rddata, 32'h1122AB44);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter that shares the single read/write port A of an `altsyncram` instance (registered address, one-cycle read latency, byte-enabled writes) between two masters, e.g. the instruction-refill and data load/store paths. It performs round-robin arbitration with a request/acknowledge handshake. It drives the RAM port directly and returns read data with a per-master valid strobe. Optionally, it clears the whole RAM after reset before granting any request.

## Interface
Parameters:
- `AW`, 11, RAM address width (matches `widthad_a`)
- `DW`, 32, data width, multiple of 8 (matches `width_a`)
- `NUMWORDS`, 2048, RAM depth, ≤ 2^AW
- `INIT_VALUE`, 0, word written during the post-reset clear (`RAM_ARB_INIT_EN` only)

Ports:
- One clock; reset is asynchronous and active-low.
- `clock`  in  1  rising-edge clock for all state
- `rst_n`  in  1  asynchronous active-low reset
- `m0_req`  in  1  master 0 request; held with command fields stable until `m0_ack`
- `m0_wren`  in  1  1 = write, 0 = read
- `m0_addr`  in  AW  word address
- `m0_wrdata`  in  DW  write data
- `m0_byteena`  in  DW/8  write byte enables
- `m0_ack`  out  1  command accepted this cycle
- `m0_rdvalid`  out  1  `m0_rddata` valid this cycle
- `m0_rddata`  out  DW  read data
- `m1_*`: identical set for master 1
- `ram_clocken`  out  1  RAM clock enable, tied 1
- `ram_wren`  out  1  RAM write enable
- `ram_address`  out  AW  RAM address
- `ram_data`  out  DW  RAM write data
- `ram_byteena`  out  DW/8  RAM byte enables
- `ram_q`  in  DW  RAM read data, valid one cycle after the address is issued
- `busy`  out  1  clear sequence in progress; no grants

## Operation
- At most one grant per cycle. The winner's `ack` is asserted combinationally in the same cycle T as the request. The `ram_*` command in T is driven from the winner's fields.
- Round-robin: a 1-bit `last` register records the most recent winner. On a conflict, the other master wins. A lone requester always wins. Reset value: `last` = 1, so m0 wins the first conflict.
- Read granted in T: the owner's `rdvalid` = 1 in T+1. Both `rddata` outputs carry `ram_q` unconditionally; only `rdvalid` qualifies them.
- Write granted in T: `ram_wren` = 1 in T. There is no response strobe.
- With no grant, `ram_wren` = 0. `ram_address` holds its last value, so there is no spurious write.
- Back-to-back: a write in T followed by a read of the same address in T+1 returns the new data in T+2. The arbiter needs no forwarding.
- Throughput: one command per cycle total, including alternating grants under continuous conflict.

## Timing
- Reset values: `m0_ack`, `m1_ack`, `m0_rdvalid`, `m1_rdvalid`, `ram_wren` = 0. `busy` = 1 with `RAM_ARB_INIT_EN`, 0 without. `ram_address` = 0.
- Read latency: request/ack in T, data in T+1. This is fixed and does not depend on contention.
- Reset asserted mid-operation: a pending `rdvalid` is dropped and does not appear after reset release. `last` returns to 1 and the clear sequence restarts at address 0.
- A `req` that is dropped before `ack` is simply withdrawn. A loser keeps `req` asserted and is granted the next cycle.

## Configuration
- Macro `RAM_ARB_INIT_EN`.
- Defined:
  - After `rst_n` deasserts, an address counter walks 0..NUMWORDS-1, one word per cycle, with `ram_wren` = 1, all byte enables set and `ram_data` = `INIT_VALUE`.
  - `busy` = 1 and no `ack` is given for exactly NUMWORDS cycles.
  - `busy` falls in the cycle after the write to address NUMWORDS-1, and the first grant is possible in that cycle.
- Undefined: the counter logic is absent, `busy` is tied 0, and grants are possible in the first cycle after reset release.

## Test plan
- m0 writes 0xDEADBEEF to address 0x010, then reads 0x010 → `m0_ack` in each request cycle; `m0_rdvalid` one cycle after the read ack with `m0_rddata` = 0xDEADBEEF.
- Both masters request reads every cycle for 8 cycles → acks alternate m0, m1, m0, …; each `rdvalid` falls exactly one cycle after its ack; 8 commands in 8 cycles.
- Write with byteena = 4'b0010 and data 0x0000AB00 over 0x11223344 → a later read returns 0x1122AB44.
- m1 reads 0x7FF, and `rst_n` pulses low in the cycle after the ack → no `m1_rdvalid` after release; all outputs at their reset values during reset.
- `RAM_ARB_INIT_EN`, NUMWORDS = 16, with m0 requesting from reset release → `busy` = 1 for 16 cycles; no ack until `busy` falls; a read of address 5 returns `INIT_VALUE`.
- Write to 0x020 in T by m0 and read of 0x020 in T+1 by m1 → `m1_rddata` in T+2 equals the new data.
